// File: rtl/seed_collector.sv
// Collects in_len entropy bytes LSB-first into linear_out, guarded by a repetition-count health test.
// seed_valid rises in_len+1 cycles after start when in_valid is held high; in_ready is high only while collecting.
module seed_collector #(
    parameter int in_len     = 32,
    parameter int RCT_CUTOFF = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [in_len*8-1:0] linear_out,
    output logic                seed_valid,
    output logic                busy,
    output logic                rct_fail
);

    localparam int CW = $clog2(in_len + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, FAIL} state_t;

    state_t         state;
    logic [CW-1:0]  byte_cnt;
    logic [7:0]     rep_cnt;
    logic [7:0]     last_byte;
    logic [7:0]     rep_next;
    logic           xfer;

    assign xfer = in_valid && in_ready;

    // The first byte of a seed never compares against a byte from a previous seed.
    always_comb begin
        rep_next = 8'd1;
        if (byte_cnt != '0 && in_data == last_byte)
            rep_next = rep_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            linear_out <= '0;
            byte_cnt   <= '0;
            rep_cnt    <= '0;
            last_byte  <= '0;
            in_ready   <= 1'b0;
            seed_valid <= 1'b0;
            busy       <= 1'b0;
            rct_fail   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state      <= COLLECT;
                        linear_out <= '0;
                        byte_cnt   <= '0;
                        rep_cnt    <= '0;
                        seed_valid <= 1'b0;
                        rct_fail   <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        last_byte <= in_data;
                        rep_cnt   <= rep_next;
                        // A trip on the final byte must win over completion.
                        if (rep_next == 8'(RCT_CUTOFF)) begin
                            state      <= FAIL;
                            rct_fail   <= 1'b1;
                            linear_out <= '0;
                            in_ready   <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            linear_out[8*byte_cnt +: 8] <= in_data;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == CW'(in_len - 1)) begin
                                state      <= DONE;
                                seed_valid <= 1'b1;
                                in_ready   <= 1'b0;
                                busy       <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
